// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared encodings and defaults for the EX/MEM pipeline latch
package ex_mem_stage_pkg;

  typedef enum logic [1:0] {
    STATE_RUN    = 2'd0,
    STATE_BUBBLE = 2'd1,
    STATE_HOLD   = 2'd2
  } stage_state_e;

  localparam int   NOP_REG_ADDR = 0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_STALL_W = 6;
  localparam int DEF_STAGE   = 3;
  localparam int DEF_CARRY_W = 64;
  localparam int DEF_CNT_W   = 2;
  localparam int PERF_CNT_W  = 32;

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// rtl/ex_mem_stage_sat_counter.sv - saturating event counter, built only with EX_MEM_STAGE_PERF_EN
`ifdef EX_MEM_STAGE_PERF_EN
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Sticks at all-ones rather than wrapping back to zero.
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM latch with flush, bubble/hold control and multi-cycle carry
// Optional bubble/hold performance counters under EX_MEM_STAGE_PERF_EN.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int STALL_W = DEF_STALL_W,
  parameter int STAGE   = DEF_STAGE,
  parameter int CARRY_W = DEF_CARRY_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [ADDR_W-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [DATA_W-1:0]  ex_hi,
  input  logic [DATA_W-1:0]  ex_lo,
  input  logic               ex_whilo,
  input  logic [CARRY_W-1:0] carry_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               mem_valid,
  output logic [ADDR_W-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  mem_hi,
  output logic [DATA_W-1:0]  mem_lo,
  output logic               mem_whilo,
  output logic [CARRY_W-1:0] carry_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [1:0]         stage_state
`ifdef EX_MEM_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] hold_cnt
`endif
);

  if ((STAGE < 0) || (STAGE > STALL_W - 2)) begin : g_stage_range
    $error("ex_mem_stage: STAGE out of range 0..STALL_W-2");
  end

  // Clamped so an illegal STAGE still elaborates far enough to report the error above.
  localparam int HERE_IDX = (STAGE < 0) ? 0 : ((STAGE > STALL_W - 1) ? STALL_W - 1 : STAGE);
  localparam int NEXT_IDX = (HERE_IDX + 1 > STALL_W - 1) ? STALL_W - 1 : HERE_IDX + 1;

  logic stop_here;
  logic stop_next;

  assign stop_here = stall[HERE_IDX];
  assign stop_next = stall[NEXT_IDX];

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               whilo_q, whilo_d;
  logic [CARRY_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  stage_state_e       state_q, state_d;

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (flush) begin
      valid_d = 1'b0;
      wd_d    = ADDR_W'(NOP_REG_ADDR);
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      carry_d = '0;
      cnt_d   = '0;
      state_d = STATE_BUBBLE;
    end else if ((stop_here == STOP) && (stop_next == NO_STOP)) begin
      // Downstream keeps moving: send a bubble, but let the multi-cycle op keep stepping.
      valid_d = 1'b0;
      wd_d    = ADDR_W'(NOP_REG_ADDR);
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      carry_d = carry_i;
      cnt_d   = cnt_i;
      state_d = STATE_BUBBLE;
    end else if (stop_here == NO_STOP) begin
      valid_d = ex_valid;
      wd_d    = ex_wd;
      wreg_d  = ex_wreg & ex_valid;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo & ex_valid;
      carry_d = '0;
      cnt_d   = '0;
      state_d = STATE_RUN;
    end else begin
      carry_d = carry_i;
      cnt_d   = cnt_i;
      state_d = STATE_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wd_q    <= ADDR_W'(NOP_REG_ADDR);
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      carry_q <= '0;
      cnt_q   <= '0;
      state_q <= STATE_RUN;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign mem_valid   = valid_q;
  assign mem_wd      = wd_q;
  assign mem_wreg    = wreg_q;
  assign mem_wdata   = wdata_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign mem_whilo   = whilo_q;
  assign carry_o     = carry_q;
  assign cnt_o       = cnt_q;
  assign stage_state = state_q;

`ifdef EX_MEM_STAGE_PERF_EN
  logic bubble_inc;
  logic hold_inc;

  assign bubble_inc = flush | (stop_here & ~stop_next);
  assign hold_inc   = ~flush & stop_here & stop_next;

  sat_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.W(PERF_CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_inc),
    .count (hold_cnt)
  );
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage (EX_MEM_STAGE_PERF_EN optional)
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] carry_i;
  logic [1:0]  cnt_i;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] carry_o;
  logic [1:0]  cnt_o;
  logic [1:0]  stage_state;
`ifdef EX_MEM_STAGE_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] hold_cnt;
`endif

  ex_mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .ex_whilo    (ex_whilo),
    .carry_i     (carry_i),
    .cnt_i       (cnt_i),
    .mem_valid   (mem_valid),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .mem_whilo   (mem_whilo),
    .carry_o     (carry_o),
    .cnt_o       (cnt_o),
    .stage_state (stage_state)
`ifdef EX_MEM_STAGE_PERF_EN
    ,
    .bubble_cnt  (bubble_cnt),
    .hold_cnt    (hold_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the four update rules of the stage applied to whole-instruction records.
  logic        m_valid, m_wreg, m_whilo;
  logic [4:0]  m_wd;
  logic [31:0] m_wdata, m_hi, m_lo;
  logic [63:0] m_carry;
  logic [1:0]  m_cnt;
  int          m_state;
  longint      m_bub, m_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_valid, m_wreg, m_whilo} <= 3'b000;
      m_wd <= 5'd0; m_wdata <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
      m_carry <= 64'd0; m_cnt <= 2'd0; m_state <= 0;
      m_bub <= 0; m_hold <= 0;
    end else if (flush || (stall[3] && !stall[4])) begin
      {m_valid, m_wreg, m_whilo} <= 3'b000;
      m_wd <= 5'd0; m_wdata <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
      m_carry <= flush ? 64'd0 : carry_i;
      m_cnt   <= flush ? 2'd0 : cnt_i;
      m_state <= 1;
      m_bub   <= (m_bub < 64'hFFFF_FFFF) ? m_bub + 1 : m_bub;
    end else if (!stall[3]) begin
      m_valid <= ex_valid;
      m_wreg  <= ex_valid && ex_wreg;
      m_whilo <= ex_valid && ex_whilo;
      m_wd <= ex_wd; m_wdata <= ex_wdata; m_hi <= ex_hi; m_lo <= ex_lo;
      m_carry <= 64'd0; m_cnt <= 2'd0; m_state <= 0;
    end else begin
      m_carry <= carry_i; m_cnt <= cnt_i; m_state <= 2;
      m_hold  <= (m_hold < 64'hFFFF_FFFF) ? m_hold + 1 : m_hold;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cyc_mem_valid", 64'(mem_valid), 64'(m_valid));
      check("cyc_mem_wd",    64'(mem_wd),    64'(m_wd));
      check("cyc_mem_wreg",  64'(mem_wreg),  64'(m_wreg));
      check("cyc_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      check("cyc_mem_hi",    64'(mem_hi),    64'(m_hi));
      check("cyc_mem_lo",    64'(mem_lo),    64'(m_lo));
      check("cyc_mem_whilo", 64'(mem_whilo), 64'(m_whilo));
      check("cyc_carry_o",   carry_o,        m_carry);
      check("cyc_cnt_o",     64'(cnt_o),     64'(m_cnt));
      check("cyc_state",     64'(stage_state), 64'(m_state));
`ifdef EX_MEM_STAGE_PERF_EN
      check("cyc_bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
      check("cyc_hold_cnt",   64'(hold_cnt),   64'(m_hold));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdat, input logic [31:0] hi,
                        input logic [31:0] lo, input logic whl);
    ex_valid = v; ex_wd = wd; ex_wreg = wr; ex_wdata = wdat;
    ex_hi = hi; ex_lo = lo; ex_whilo = whl;
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    carry_i = 64'd0; cnt_i = 2'd0;
    step();
    step();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset test: latch a carry, then reset mid-cycle
    set_ex(1'b1, 5'd9, 1'b1, 32'hCAFE_0001, 32'h1, 32'h2, 1'b1);
    step();
    stall = 6'b001000; carry_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd3;
    step();
    check("pre_rst_carry", carry_o, 64'hDEAD_BEEF_0000_0001);
    check("pre_rst_cnt", 64'(cnt_o), 64'd3);
    #1 rst = 1'b1;
    #1;
    check("rst_carry", carry_o, 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_mem_wd", 64'(mem_wd), 64'd0);
    check("rst_mem_flags", 64'({mem_valid, mem_wreg, mem_whilo}), 64'd0);
    check("rst_mem_data", 64'(mem_wdata | mem_hi | mem_lo), 64'd0);
    check("rst_state", 64'(stage_state), 64'd0);
    #2 rst = 1'b0;
    stall = 6'd0; carry_i = 64'd0; cnt_i = 2'd0;

    // Capture test
    set_ex(1'b1, 5'd7, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    step();
    check("cap_wd", 64'(mem_wd), 64'd7);
    check("cap_wdata", 64'(mem_wdata), 64'h1234_5678);
    check("cap_wreg", 64'(mem_wreg), 64'd1);
    check("cap_state", 64'(stage_state), 64'd0);

    // Bubble test
    stall = 6'b001000; carry_i = 64'h5; cnt_i = 2'b01;
    step();
    check("bub_wreg", 64'(mem_wreg), 64'd0);
    check("bub_wd", 64'(mem_wd), 64'd0);
    check("bub_carry", carry_o, 64'h5);
    check("bub_cnt", 64'(cnt_o), 64'd1);
    check("bub_state", 64'(stage_state), 64'd1);
    stall = 6'd0;
    step();
    check("bub_done_carry", carry_o, 64'd0);
    check("bub_done_cnt", 64'(cnt_o), 64'd0);

    // Hold test
    set_ex(1'b1, 5'd3, 1'b1, 32'h0000_0333, 32'h33, 32'h44, 1'b1);
    step();
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 5'(10 + i), 1'b1, 32'(i), 32'hF0 + 32'(i), 32'hE0, 1'b0);
      carry_i = 64'd100 + 64'(i); cnt_i = 2'(i);
      step();
      check("hold_wd", 64'(mem_wd), 64'd3);
      check("hold_wdata", 64'(mem_wdata), 64'h333);
      check("hold_carry", carry_o, 64'd100 + 64'(i));
      check("hold_state", 64'(stage_state), 64'd2);
    end
`ifdef EX_MEM_STAGE_PERF_EN
    check("perf_hold_cnt", 64'(hold_cnt), 64'd3);
    check("perf_bubble_cnt", 64'(bubble_cnt), 64'd1);
`endif

    // Flush test, overriding the hold combination
    flush = 1'b1; carry_i = 64'd77; cnt_i = 2'd2;
    step();
    check("flush_wd", 64'(mem_wd), 64'd0);
    check("flush_flags", 64'({mem_valid, mem_wreg, mem_whilo}), 64'd0);
    check("flush_carry", carry_o, 64'd0);
    check("flush_cnt", 64'(cnt_o), 64'd0);
    check("flush_state", 64'(stage_state), 64'd1);
    flush = 1'b0;

    // Valid gating test
    stall = 6'd0;
    set_ex(1'b0, 5'd12, 1'b1, 32'h5555_0000, 32'hAAAA, 32'hBBBB, 1'b1);
    step();
    check("vg_wreg", 64'(mem_wreg), 64'd0);
    check("vg_whilo", 64'(mem_whilo), 64'd0);
    check("vg_valid", 64'(mem_valid), 64'd0);
    check("vg_hi", 64'(mem_hi), 64'hAAAA);
    check("vg_wd", 64'(mem_wd), 64'd12);

    // Only downstream stalled: this stage still captures
    stall = 6'b010000;
    set_ex(1'b1, 5'd21, 1'b0, 32'h0BAD_F00D, 32'h1, 32'h2, 1'b1);
    step();
    check("dn_stall_wd", 64'(mem_wd), 64'd21);
    check("dn_stall_whilo", 64'(mem_whilo), 64'd1);
    check("dn_stall_state", 64'(stage_state), 64'd0);

    // Flush with no stall and a hold after it
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_nostall_wd", 64'(mem_wd), 64'd0);

    // Mixed vectors, checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      stall = 6'($urandom_range(0, 63));
      flush = ($urandom_range(0, 7) == 0);
      set_ex(1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
      carry_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
      step();
    end
    flush = 1'b0; stall = 6'd0;
    step();
    cmp_en = 1'b0;
    #10;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised EX/MEM pipeline latch that succeeds the fixed 32-bit stage register. It carries the GPR write-back fields, HI/LO write-back fields and a valid bit from execute to memory. It adds a synchronous flush and an explicit RUN/BUBBLE/HOLD state output. Across stalls it preserves the carry state (partial accumulator and step counter) of a multi-cycle execute operation such as madd/msub.

Parameters:
- DATA_W, 32, width of the GPR write data and of each of HI and LO.
- ADDR_W, 5, width of the destination register address.
- STALL_W, 6, width of the pipeline stall vector.
- STAGE, 3, index of this stage's bit in the stall vector; the downstream bit is STAGE+1. Legal range is 0 to STALL_W-2.
- CARRY_W, 64, width of the multi-cycle carry (partial accumulator).
- CNT_W, 2, width of the multi-cycle step counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  STALL_W  pipeline stall vector; 1 means stop.
- flush  in  1  synchronous kill of the stage contents.
- ex_valid  in  1  the execute stage holds a real instruction.
- ex_wd  in  ADDR_W  destination register address.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  DATA_W  GPR write data.
- ex_hi  in  DATA_W  HI write data.
- ex_lo  in  DATA_W  LO write data.
- ex_whilo  in  1  HI/LO write enable.
- carry_i  in  CARRY_W  carry state from the execute stage.
- cnt_i  in  CNT_W  step count from the execute stage.
- mem_valid  out  1  registered ex_valid.
- mem_wd  out  ADDR_W  registered ex_wd.
- mem_wreg  out  1  registered ex_wreg.
- mem_wdata  out  DATA_W  registered ex_wdata.
- mem_hi  out  DATA_W  registered ex_hi.
- mem_lo  out  DATA_W  registered ex_lo.
- mem_whilo  out  1  registered ex_whilo.
- carry_o  out  CARRY_W  carry state fed back to the execute stage.
- cnt_o  out  CNT_W  step count fed back to the execute stage.
- stage_state  out  2  state register: 0 = RUN, 1 = BUBBLE, 2 = HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all mem_* outputs are 0, and mem_wd is 0 (the NOP register address). carry_o = 0, cnt_o = 0, stage_state = RUN. A reset asserted mid-operation discards any in-flight carry and count immediately, without waiting for a clock edge.
- Update priority at each rising clk edge, highest first:
  1. flush = 1: all mem_* fields go to the bubble value (valid/wreg/whilo = 0, data = 0, wd = 0). carry_o and cnt_o are cleared. State becomes BUBBLE. Flush overrides any stall combination.
  2. stall[STAGE] = 1 and stall[STAGE+1] = 0: bubble is inserted into all mem_* fields. carry_o <= carry_i and cnt_o <= cnt_i, so the multi-cycle operation keeps progressing. State becomes BUBBLE.
  3. stall[STAGE] = 0: all ex_* fields are captured into mem_*. carry_o and cnt_o are cleared, because the operation completed in execute. State becomes RUN.
  4. stall[STAGE] = 1 and stall[STAGE+1] = 1: all mem_* fields hold their current values. carry_o <= carry_i and cnt_o <= cnt_i. State becomes HOLD.
- Latency: one cycle from the ex_* inputs to the mem_* outputs. There is no combinational path from input to output.
- Valid gating: on a capture with ex_valid = 0, mem_wreg and mem_whilo are forced to 0. The data fields are still captured.
- stage_state transitions follow rows 1-4 above. It is purely a registered indication and never feeds back into the datapath.
- Widths: every field is a straight copy; no arithmetic is performed on any field.
- STAGE is range-checked at elaboration; an out-of-range value causes a $error.

Optional Feature:
- Macro: EX_MEM_STAGE_PERF_EN.
- Defined: adds two outputs, bubble_cnt (32 bits) and hold_cnt (32 bits). Each counter increments by 1 on every edge that takes row 1 or 2 (bubble_cnt) or row 4 (hold_cnt). Both saturate at all-ones and do not wrap. Both reset to 0 on rst only; flush does not clear them.
- Not defined: neither port nor either counter exists. Core behaviour is identical in both builds.

Decomposition:
- Shared package/defines: the stage_state encodings (STATE_RUN, STATE_BUBBLE, STATE_HOLD), the NOP register address, the Stop/NoStop levels and the default widths.
- Sub-module: the saturating counter is instantiated twice as sat_counter, present only when EX_MEM_STAGE_PERF_EN is defined.
- All other logic stays in a single always block with asynchronous reset.

Test Plan:
- Reset test: assert rst mid-cycle with carry_i = 64'hDEAD_BEEF_0000_0001 already latched. Required: carry_o = 0, cnt_o = 0, all mem_* = 0 and stage_state = 0 immediately, without waiting for a clk edge.
- Capture test: stall = 0, ex_wd = 5'd7, ex_wdata = 32'h1234_5678, ex_wreg = 1, ex_valid = 1. Required: the next edge gives mem_wd = 7, mem_wdata = 32'h1234_5678, mem_wreg = 1, stage_state = RUN.
- Bubble test: stall = 6'b001000, carry_i = 64'h5, cnt_i = 2'b01. Required: mem_wreg = 0, mem_wd = 0, carry_o = 64'h5, cnt_o = 1, stage_state = BUBBLE. Then stall = 0. Required: carry_o = 0, cnt_o = 0.
- Hold test: capture wd = 3, then stall = 6'b011000 for 3 cycles with changing ex_*. Required: mem_wd stays 3, carry_o tracks carry_i each cycle, stage_state = HOLD. With the perf macro defined, hold_cnt = 3.
- Flush test: flush = 1 together with stall = 6'b011000. Required: the bubble is inserted, carry_o = 0, stage_state = BUBBLE.
- Valid-gating test: ex_valid = 0 with ex_wreg = 1, ex_whilo = 1 and stall = 0. Required: mem_wreg = 0, mem_whilo = 0, mem_valid = 0.
